system_alarm_out_pio: RTL and testbench
=======================================

# system_alarm_out_pio

Avalon-MM slave output port for the alarm-clock SoC. The Nios II core writes it to drive the alarm buzzer and indicator LEDs. Beside a plain data register it carries a blink mask and a programmable prescaler, so selected output bits toggle at a software-set rate without CPU involvement. It sits on the system interconnect beside the switch/button input PIOs and mirrors their register style: word-addressed, one-cycle registered read.

## Interface
- WIDTH, default 8: number of output bits driven on out_port.
- PERIOD_RESET, default 0: reset value of the PERIOD register. 0 means blinking is disabled.
- clk  input  1: system clock. Single clock domain.
- reset_n  input  1: asynchronous, active-low reset.
- address  input  2: word address. 0=DATA, 1=BLINK, 2=PERIOD, 3=CONTROL.
- chipselect  input  1: qualifies writes.
- write_n  input  1: active-low write strobe. A write occurs when chipselect=1 and write_n=0.
- writedata  input  32: write data.
- readdata  output  32: registered read data.
- out_port  output  WIDTH: registered output pins.

## Operation
- **DATA (addr 0, R/W)**
  - bits [WIDTH-1:0] hold the base output value.
  - Upper bits are ignored on write and read as 0.
- **BLINK (addr 1, R/W)**
  - bits [WIDTH-1:0] are the blink mask.
  - A masked bit is forced low while phase=1.
- **PERIOD (addr 2, R/W, 32 bits)**
  - Holds the prescaler reload value.
  - Writing PERIOD loads the counter with the new value and clears phase.
- **CONTROL (addr 3)**
  - Read: bit0 = phase, other bits 0.
  - Write with bit0=1: restart, i.e. reload the counter from PERIOD and clear phase.
  - Write with bit0=0: no effect.
- **Prescaler**
  - 32-bit down-counter, decremented every cycle while PERIOD≠0.
  - When the counter is 0: reload from PERIOD and toggle phase.
  - Toggle interval is PERIOD+1 cycles; a full blink cycle is 2·(PERIOD+1) cycles.
  - If PERIOD=0: counter held at 0, phase held at 0, no toggling.
- **Output function**: out_port ← DATA & ~(BLINK & {WIDTH{phase}}), registered.
- **Read mux**
  - readdata ← zero-extended value of the register selected by address, every cycle.
  - No read strobe is used; reads have no side effects.
- **Simultaneous events**
  - A PERIOD write or CONTROL restart in the same cycle as a counter expiry wins: counter loaded, phase=0, no toggle.
  - A DATA or BLINK write in the same cycle as a phase toggle: both take effect. out_port on the next edge uses the new register value and the new phase.

## Timing
- **Reset values**
  - DATA=0, BLINK=0, PERIOD=PERIOD_RESET, counter=PERIOD_RESET, phase=0.
  - out_port=0, readdata=0.
  - Reset asserted mid-operation clears everything immediately (asynchronous).
- **Write to visible output**
  - Write sampled at edge N; register updated at N.
  - out_port reflects it at edge N+1.
- **Read latency**: address presented before edge N → readdata valid after edge N (1 cycle).
- **Phase to output**: phase toggles at edge N → out_port changes at N+1.
- **Write-after-write**: back-to-back writes on consecutive cycles are all accepted. No wait states; waitrequest is not provided.

## Structure
- Shared package holds:
  - register address constants ADDR_DATA=0, ADDR_BLINK=1, ADDR_PERIOD=2, ADDR_CONTROL=3;
  - CONTROL bit index CTRL_RESTART=0.
- One natural sub-module: alarm_blink_prescaler.
  - Contains the counter, reload value, phase, and load/restart inputs.
  - Exposes phase.
- The top level holds the register file, read mux and output register.

## Test plan
- **Reset**
  - Stimulus: assert reset_n=0 with random bus activity, then release.
  - Required: out_port=0, readdata=0; reads of addr 0–3 return 0,0,PERIOD_RESET,0.
- **Plain output, PERIOD=0**
  - Stimulus: write DATA=0xA5.
  - Required: out_port=0xA5 exactly one cycle after the write edge; it stays 0xA5 for ≥100 cycles. Read addr 0 returns 0x000000A5.
- **Blink**
  - Stimulus: DATA=0xFF, BLINK=0x0F, PERIOD=3.
  - Required: out_port alternates 0xFF and 0xF0 every 4 cycles. CONTROL bit0 tracks phase.
- **Restart collision**
  - Stimulus: with PERIOD=3 running, write CONTROL=1 in the same cycle the counter reaches 0.
  - Required: no toggle, phase=0, next toggle 4 cycles later.
- **Reprogram period**
  - Stimulus: write PERIOD=1 while phase=1.
  - Required: phase cleared immediately (out_port=DATA one cycle later); toggling every 2 cycles thereafter.
- **Width masking and reset mid-blink**
  - Stimulus: write DATA=0xFFFF_FF3C, then assert reset_n mid-blink.
  - Required: readback after the write returns 0x0000003C; on reset, out_port=0 asynchronously and blinking stops.

Source files
------------

// File: rtl/system_alarm_out_pio_pkg.sv
// Shared register map for the alarm output PIO.
package system_alarm_out_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_BLINK   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  localparam int CTRL_RESTART = 0;

endpackage

// File: rtl/system_alarm_out_pio_blink_prescaler.sv
// Blink prescaler: holds the PERIOD reload value, a 32-bit down-counter and
// the blink phase. The phase flips every PERIOD+1 cycles; PERIOD=0 parks it.
module alarm_blink_prescaler #(
  parameter logic [31:0] PERIOD_RESET = 32'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        period_we,
  input  logic [31:0] period_wdata,
  input  logic        restart,
  output logic [31:0] period,
  output logic        phase
);

  logic [31:0] counter;

  // Loads and restarts take priority over a same-cycle expiry, so a
  // reprogram or restart never produces a stray toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period  <= PERIOD_RESET;
      counter <= PERIOD_RESET;
      phase   <= 1'b0;
    end else if (period_we) begin
      period  <= period_wdata;
      counter <= period_wdata;
      phase   <= 1'b0;
    end else if (restart) begin
      counter <= period;
      phase   <= 1'b0;
    end else if (period == 32'd0) begin
      counter <= 32'd0;
      phase   <= 1'b0;
    end else if (counter == 32'd0) begin
      counter <= period;
      phase   <= ~phase;
    end else begin
      counter <= counter - 32'd1;
    end
  end

endmodule

// File: rtl/system_alarm_out_pio.sv
// Avalon-MM output PIO for the alarm buzzer and LEDs, with per-bit blink
// masking driven by a software-programmed prescaler.
module system_alarm_out_pio
  import system_alarm_out_pio_pkg::*;
#(
  parameter int          WIDTH        = 8,
  parameter logic [31:0] PERIOD_RESET = 32'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             write_en;
  logic             period_we;
  logic             restart;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] blink_reg;
  logic [31:0]      period;
  logic             phase;
  logic [31:0]      read_mux;

  assign write_en  = chipselect & ~write_n;
  assign period_we = write_en && (address == ADDR_PERIOD);
  assign restart   = write_en && (address == ADDR_CONTROL) && writedata[CTRL_RESTART];

  alarm_blink_prescaler #(
    .PERIOD_RESET (PERIOD_RESET)
  ) u_prescaler (
    .clk          (clk),
    .reset_n      (reset_n),
    .period_we    (period_we),
    .period_wdata (writedata),
    .restart      (restart),
    .period       (period),
    .phase        (phase)
  );

  // DATA and BLINK registers; bits above WIDTH are simply dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg  <= '0;
      blink_reg <= '0;
    end else if (write_en) begin
      if (address == ADDR_DATA)  data_reg  <= writedata[WIDTH-1:0];
      if (address == ADDR_BLINK) blink_reg <= writedata[WIDTH-1:0];
    end
  end

  // Masked bits go low while phase is high; registered so the pins are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= '0;
    end else begin
      out_port <= data_reg & ~(blink_reg & {WIDTH{phase}});
    end
  end

  // Select the addressed register, zero-extended to the bus width.
  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA:    read_mux[WIDTH-1:0] = data_reg;
      ADDR_BLINK:   read_mux[WIDTH-1:0] = blink_reg;
      ADDR_PERIOD:  read_mux            = period;
      ADDR_CONTROL: read_mux[0]         = phase;
      default:      read_mux            = '0;
    endcase
  end

  // Reads are side-effect free and return one cycle after the address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= read_mux;
    end
  end

endmodule

// File: tb/tb_system_alarm_out_pio.sv
// Self-checking bench for system_alarm_out_pio: directed vector table, hand
// sequences for blink/restart/reprogram/reset corners, then random traffic
// against a cycle-count based reference model.
module tb_system_alarm_out_pio;

  localparam int          WIDTH        = 8;
  localparam logic [31:0] PERIOD_RESET = 32'd0;

  logic             clk;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int errors = 0;
  int checks = 0;

  system_alarm_out_pio #(
    .WIDTH        (WIDTH),
    .PERIOD_RESET (PERIOD_RESET)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: registers plus the number of edges since the last
  // counter load; phase follows from integer division by PERIOD+1.
  logic [7:0]  m_data;
  logic [7:0]  m_blink;
  logic [31:0] m_period;
  longint      m_k;

  function automatic bit modelPhase();
    if (m_period == 32'd0) return 1'b0;
    return ((m_k / (longint'(m_period) + 64'sd1)) % 2) == 1;
  endfunction

  function automatic logic [7:0] modelOut();
    return m_data & ~(m_blink & {8{modelPhase()}});
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_data};
      2'd1:    return {24'h0, m_blink};
      2'd2:    return m_period;
      default: return {31'h0, modelPhase()};
    endcase
  endfunction

  task automatic modelReset();
    m_data   = 8'h00;
    m_blink  = 8'h00;
    m_period = PERIOD_RESET;
    m_k      = 0;
  endtask

  task automatic modelEdge(input logic [1:0] a, input logic we, input logic [31:0] wd);
    bit load;
    load = 1'b0;
    if (we) begin
      case (a)
        2'd0: m_data  = wd[7:0];
        2'd1: m_blink = wd[7:0];
        2'd2: begin m_period = wd; load = 1'b1; end
        default: if (wd[0]) load = 1'b1;
      endcase
    end
    m_k = load ? 0 : m_k + 1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one bus cycle, advance the model on the edge, compare 1 unit later.
  task automatic applyStimulus(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    logic [7:0]  eo;
    logic [31:0] er;
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    eo = modelOut();
    er = modelRead(a);
    @(posedge clk);
    modelEdge(a, cs & ~wn, wd);
    #1;
    checkOutput("model out_port", {24'h0, out_port}, {24'h0, eo});
    checkOutput("model readdata", readdata, er);
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0]  exp_o;
    logic [31:0] exp_r;
    logic [1:0]  ra;
    logic        rcs;
    logic        rwn;
    logic [31:0] rwd;

    vecs[0] = '{2'd0, 1'b0, 32'h0,  8'h00, 32'h0};
    vecs[1] = '{2'd1, 1'b0, 32'h0,  8'h00, 32'h0};
    vecs[2] = '{2'd2, 1'b0, 32'h0,  8'h00, PERIOD_RESET};
    vecs[3] = '{2'd3, 1'b0, 32'h0,  8'h00, 32'h0};
    vecs[4] = '{2'd0, 1'b1, 32'hA5, 8'h00, 32'h0};
    vecs[5] = '{2'd0, 1'b0, 32'h0,  8'hA5, 32'h0000_00A5};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    modelReset();

    // Reset held with random bus traffic: everything stays zero.
    for (int i = 0; i < 4; i++) begin
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = $urandom;
      @(posedge clk);
      #1;
      checkOutput("reset out_port", {24'h0, out_port}, 32'h0);
      checkOutput("reset readdata", readdata, 32'h0);
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset_n    = 1'b1;

    // Directed table: reset readback and plain DATA write with PERIOD=0.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].addr, 1'b1, ~vecs[i].wr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d out_port", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
      checkOutput($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
    end

    // Output holds steady with blinking disabled.
    for (int i = 0; i < 100; i++) begin
      applyStimulus(2'd0, 1'b1, 1'b1, 32'h0);
      checkOutput("hold A5", {24'h0, out_port}, 32'h0000_00A5);
    end

    // Blink: DATA=FF, BLINK=0F, PERIOD=3 gives four cycles per level.
    applyStimulus(2'd0, 1'b1, 1'b0, 32'hFF);
    applyStimulus(2'd1, 1'b1, 1'b0, 32'h0F);
    applyStimulus(2'd2, 1'b1, 1'b0, 32'd3);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(2'd3, 1'b1, 1'b1, 32'h0);
      exp_r = ((i - 1) / 4) % 2;
      exp_o = exp_r[0] ? 8'hF0 : 8'hFF;
      checkOutput($sformatf("blink out %0d", i), {24'h0, out_port}, {24'h0, exp_o});
      checkOutput($sformatf("blink phase %0d", i), readdata, exp_r);
    end

    // Restart landing exactly on the expiry edge: no toggle, fresh interval.
    applyStimulus(2'd2, 1'b1, 1'b0, 32'd3);
    for (int i = 0; i < 3; i++) applyStimulus(2'd3, 1'b1, 1'b1, 32'h0);
    applyStimulus(2'd3, 1'b1, 1'b0, 32'h1);
    for (int j = 1; j <= 5; j++) begin
      applyStimulus(2'd3, 1'b1, 1'b1, 32'h0);
      exp_r = (j >= 5) ? 32'h1 : 32'h0;
      exp_o = exp_r[0] ? 8'hF0 : 8'hFF;
      checkOutput($sformatf("restart out %0d", j), {24'h0, out_port}, {24'h0, exp_o});
      checkOutput($sformatf("restart phase %0d", j), readdata, exp_r);
    end

    // Reprogram PERIOD=1 while phase is high: phase clears, then 2-cycle toggles.
    applyStimulus(2'd2, 1'b1, 1'b0, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(2'd3, 1'b1, 1'b1, 32'h0);
      exp_r = ((i - 1) / 2) % 2;
      exp_o = exp_r[0] ? 8'hF0 : 8'hFF;
      checkOutput($sformatf("reprog out %0d", i), {24'h0, out_port}, {24'h0, exp_o});
      checkOutput($sformatf("reprog phase %0d", i), readdata, exp_r);
    end

    // Width masking on DATA, then asynchronous reset in the middle of blinking.
    applyStimulus(2'd0, 1'b1, 1'b0, 32'hFFFF_FF3C);
    applyStimulus(2'd0, 1'b1, 1'b1, 32'h0);
    checkOutput("width mask readback", readdata, 32'h0000_003C);
    for (int i = 0; i < 3; i++) applyStimulus(2'd3, 1'b1, 1'b1, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset out_port", {24'h0, out_port}, 32'h0);
    checkOutput("async reset readdata", readdata, 32'h0);
    modelReset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("held reset out_port", {24'h0, out_port}, 32'h0);
    end
    reset_n = 1'b1;
    applyStimulus(2'd0, 1'b1, 1'b0, 32'hFF);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'd3, 1'b1, 1'b1, 32'h0);
      checkOutput("post reset no blink out", {24'h0, out_port}, 32'h0000_00FF);
      checkOutput("post reset phase", readdata, 32'h0);
    end

    // Random bus traffic against the model.
    for (int i = 0; i < 600; i++) begin
      ra  = 2'($urandom_range(0, 3));
      rcs = ($urandom_range(0, 3) != 0);
      rwn = 1'($urandom_range(0, 1));
      rwd = (ra == 2'd2) ? 32'($urandom_range(0, 6)) : $urandom;
      applyStimulus(ra, rcs, rwn, rwd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
